imem_bank_port: RTL and testbench

- Per-bank access port for the shared, banked instruction memory.
- One instance sits in front of each instruction ROM bank, downstream of the per-core address-to-bank decoders.
- Arbitrates round-robin among up to N_CORES fetch requests, drives the bank ROM address from the winning core, and registers the ROM data.
- Returns the data to the winner one cycle later with a one-hot valid. Also counts contention cycles for performance debug.

---
 rtl/imem_bank_port.sv | 106 ++++++++++
 tb/tb_imem_bank_port.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imem_bank_port.sv
// Per-bank port in front of one instruction ROM bank: round-robin arbitration
// among core fetch requests, ROM address mux, registered read data and a contention counter.
module imem_bank_port #(
    parameter int N_CORES = 3,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int PTR_W  = $clog2(N_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES-1:0]          req,
    input  logic [N_CORES*ADDR_W-1:0]   addr,
    output logic [N_CORES-1:0]          gnt,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic [N_CORES-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [PTR_W-1:0]            ptr,
    output logic [CNT_W-1:0]            conflict_cnt
);

    logic             found;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             multi_req;
    logic             seen_req;

    // Scan from ptr upward (mod N_CORES); the first requester wins.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        gnt      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_CORES; k++) begin
            scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_CORES)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_CORES);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (gnt[i]) begin
                rom_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (found) begin
            if (gnt_idx == PTR_W'(N_CORES-1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = gnt_idx + PTR_W'(1);
            end
        end
    end

    // Contention means at least two requesters in the same cycle.
    always_comb begin
        multi_req = 1'b0;
        seen_req  = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (req[i]) begin
                if (seen_req) begin
                    multi_req = 1'b1;
                end
                seen_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            conflict_cnt <= '0;
        end else begin
            ptr       <= ptr_next;
            rsp_valid <= gnt;
            if (found) begin
                rsp_data <= rom_data;
            end
            if (multi_req && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_bank_port.sv
// Directed self-checking bench for imem_bank_port: arbitration order, data return,
// reset mid-operation, idle hold and contention counter saturation (CNT_W=4 instance).
module tb_imem_bank_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [17:0] addr;
    logic [2:0]  gnt;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  ptr;
    logic [15:0] conflict_cnt;

    logic [2:0]  req4;
    logic [17:0] addr4;
    logic [2:0]  gnt4;
    logic [5:0]  rom_addr4;
    logic [31:0] rom_data4;
    logic [2:0]  rsp_valid4;
    logic [31:0] rsp_data4;
    logic [1:0]  ptr4;
    logic [3:0]  conflict_cnt4;

    int total = 0;
    int bad   = 0;

    logic [2:0]  exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [31:0] exp_d [4] = '{32'h100A, 32'h1014, 32'h101E, 32'h100A};
    logic [1:0]  exp_p [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

    always #5 clk = ~clk;

    // Bench ROM: each word holds 0x1000 plus its address.
    assign rom_data  = 32'h1000 + 32'(rom_addr);
    assign rom_data4 = 32'h1000 + 32'(rom_addr4);

    imem_bank_port #(.N_CORES(3), .ADDR_W(6), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt),
        .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .ptr(ptr), .conflict_cnt(conflict_cnt)
    );

    imem_bank_port #(.N_CORES(3), .ADDR_W(6), .DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .addr(addr4), .gnt(gnt4),
        .rom_addr(rom_addr4), .rom_data(rom_data4), .rsp_valid(rsp_valid4),
        .rsp_data(rsp_data4), .ptr(ptr4), .conflict_cnt(conflict_cnt4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] rq);
        rst = r;
        req = rq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 3'b000;
        addr  = {6'd30, 6'd20, 6'd10};
        req4  = 3'b000;
        addr4 = {6'd3, 6'd2, 6'd1};
        tick();
        tick();
        checkOutput("rst_ptr", 32'(ptr), 32'd0);
        checkOutput("rst_vld", 32'(rsp_valid), 32'd0);
        checkOutput("rst_data", rsp_data, 32'd0);
        checkOutput("rst_cnt", 32'(conflict_cnt), 32'd0);
        checkOutput("rst_gnt_idle", 32'(gnt), 32'd0);

        // All three cores request continuously.
        applyStimulus(1'b0, 3'b111);
        checkOutput("A_rom_addr0", 32'(rom_addr), 32'd10);
        for (int k = 0; k < 4; k++) begin
            checkOutput("A_gnt", 32'(gnt), 32'(exp_g[k]));
            tick();
            checkOutput("A_vld", 32'(rsp_valid), 32'(exp_g[k]));
            checkOutput("A_data", rsp_data, exp_d[k]);
            checkOutput("A_ptr", 32'(ptr), 32'(exp_p[k]));
            checkOutput("A_cnt", 32'(conflict_cnt), 32'(k + 1));
        end

        // Reset while a grant to core 1 is pending.
        checkOutput("R_gnt_due", 32'(gnt), 32'b010);
        applyStimulus(1'b1, 3'b111);
        tick();
        checkOutput("R_vld", 32'(rsp_valid), 32'd0);
        checkOutput("R_ptr", 32'(ptr), 32'd0);
        checkOutput("R_cnt", 32'(conflict_cnt), 32'd0);
        checkOutput("R_data", rsp_data, 32'd0);
        applyStimulus(1'b0, 3'b111);
        checkOutput("R_gnt_first", 32'(gnt), 32'b001);
        tick();
        checkOutput("R_vld_first", 32'(rsp_valid), 32'b001);
        checkOutput("R_data_first", rsp_data, 32'h100A);

        // Only core 2 requests from reset.
        addr = {6'd5, 6'd0, 6'd0};
        applyStimulus(1'b1, 3'b100);
        tick();
        checkOutput("B_vld_rst", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 3'b100);
        checkOutput("B_gnt", 32'(gnt), 32'b100);
        checkOutput("B_rom_addr", 32'(rom_addr), 32'd5);
        tick();
        checkOutput("B_vld", 32'(rsp_valid), 32'b100);
        checkOutput("B_data", rsp_data, 32'h1005);
        checkOutput("B_ptr", 32'(ptr), 32'd0);
        checkOutput("B_cnt", 32'(conflict_cnt), 32'd0);

        // Move ptr to 1, then req=101.
        addr = {6'd5, 6'd0, 6'd7};
        applyStimulus(1'b0, 3'b001);
        checkOutput("C_gnt_setup", 32'(gnt), 32'b001);
        tick();
        checkOutput("C_ptr_setup", 32'(ptr), 32'd1);
        applyStimulus(1'b0, 3'b101);
        checkOutput("C_gnt1", 32'(gnt), 32'b100);
        checkOutput("C_rom_addr1", 32'(rom_addr), 32'd5);
        tick();
        checkOutput("C_ptr1", 32'(ptr), 32'd0);
        checkOutput("C_vld1", 32'(rsp_valid), 32'b100);
        checkOutput("C_data1", rsp_data, 32'h1005);
        checkOutput("C_cnt1", 32'(conflict_cnt), 32'd1);
        checkOutput("C_gnt2", 32'(gnt), 32'b001);
        checkOutput("C_rom_addr2", 32'(rom_addr), 32'd7);
        tick();
        checkOutput("C_ptr2", 32'(ptr), 32'd1);
        checkOutput("C_vld2", 32'(rsp_valid), 32'b001);
        checkOutput("C_data2", rsp_data, 32'h1007);
        checkOutput("C_cnt2", 32'(conflict_cnt), 32'd2);

        // Idle cycles hold data and pointer.
        applyStimulus(1'b0, 3'b000);
        checkOutput("D_gnt", 32'(gnt), 32'd0);
        checkOutput("D_rom_addr", 32'(rom_addr), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("D_vld", 32'(rsp_valid), 32'd0);
            checkOutput("D_data", rsp_data, 32'h1007);
            checkOutput("D_ptr", 32'(ptr), 32'd1);
            checkOutput("D_cnt", 32'(conflict_cnt), 32'd2);
        end

        // 4-bit counter saturates under req=011.
        req4 = 3'b011;
        #1;
        for (int k = 0; k < 14; k++) tick();
        checkOutput("E_cnt14", 32'(conflict_cnt4), 32'd14);
        tick();
        checkOutput("E_cnt15", 32'(conflict_cnt4), 32'd15);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("E_cnt_sat", 32'(conflict_cnt4), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
